pattern_sweep_capture: RTL and testbench
========================================

Name: pattern_sweep_capture

Overview:
- Synthesizable stimulus/response engine for trojan-detection benchmark characterization.
- Sweeps every input pattern of a DUT with a parametrised input width: 0 through 2^IN_W-1, ascending.
- Waits a programmable settle time per pattern, samples the DUT response, and emits one record per pattern over a valid/ready stream to the logging side.
- Sits between the sequencing testbench and the DUT. Generalizes single-bit, two-pattern capture to N-bit inputs, M-bit outputs, settle control, back-pressure, abort and an optional signature.

Parameters:
- IN_W, 1, DUT input width, 1..16.
- OUT_W, 1, DUT output width, 1..32.
- SETTLE, 1, cycles each pattern is held before sampling, >=1.
- SIG_W, 16, signature width, >=OUT_W (used only with the optional feature).
- POLY, 16'h1021, signature feedback polynomial, SIG_W bits.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate the sweep; return to IDLE next edge.
- stim  output  IN_W  pattern driven to the DUT.
- resp  input  OUT_W  DUT response.
- rec_valid  output  1  record available.
- rec_ready  input  1  consumer accepts the record.
- rec_stim  output  IN_W  pattern of the record.
- rec_resp  output  OUT_W  sampled response.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pat_count  output  IN_W+1  records accepted in the current or last sweep.
- signature  output  SIG_W  MISR value; present only with SWEEP_MISR_EN.

Behaviour:
- Reset values: state=IDLE, stim=0, rec_valid=0, rec_stim=0, rec_resp=0, busy=0, done=0, pat_count=0, signature=0.
- Reset applied mid-sweep wins over every other input on that edge.
- States: IDLE, APPLY, EMIT, DONE.
- IDLE:
  - stim=0.
  - start=1 -> APPLY; settle counter loaded with SETTLE-1; pat_count cleared to 0; signature cleared to 0.
- APPLY:
  - stim holds the current pattern.
  - Counter nonzero: decrement it.
  - Counter zero: latch rec_stim<=stim and rec_resp<=resp, set rec_valid<=1, go to EMIT.
  - APPLY therefore lasts exactly SETTLE cycles.
- EMIT:
  - rec_valid=1; rec_stim and rec_resp held stable until the handshake.
  - Handshake (rec_valid & rec_ready on an edge): pat_count increments, rec_valid<=0.
  - After the handshake, if stim == all-ones -> DONE; otherwise stim<=stim+1, reload the counter, -> APPLY.
  - rec_ready low stalls indefinitely; stim and the counter are frozen.
- DONE: done=1 for exactly one cycle, then -> IDLE (stim returns to 0).
- Timing:
  - Per-pattern cost is SETTLE+1 cycles when rec_ready is held high.
  - Total sweep is 2^IN_W*(SETTLE+1)+1 cycles from start to the done pulse.
- start while busy: ignored.
- abort:
  - Honored in APPLY/EMIT; next state IDLE, rec_valid<=0, no done pulse.
  - pat_count and signature keep their values.
  - abort has priority over a simultaneous handshake: that record is not counted.
  - abort and start together in IDLE: start is ignored.
- Wrap-around: stim never wraps; the all-ones pattern is the final one.
- pat_count reaches 2^IN_W exactly, hence the IN_W+1 width.

Optional Feature:
- Macro SWEEP_MISR_EN.
- Defined:
  - signature port exists.
  - On each accepted record: sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(rec_resp).
  - Cleared on start and on reset; held through DONE and IDLE.
- Undefined: the signature port and its logic are absent; all other behaviour is identical.

Test Plan:
- IN_W=1, OUT_W=1, SETTLE=1, resp=~stim, rec_ready=1, pulse start:
  - Records (0,1) then (1,0) on consecutive EMIT cycles.
  - done pulses 5 cycles after start.
  - pat_count=2.
  - signature=16'h0002 with SWEEP_MISR_EN.
- IN_W=3, SETTLE=3, resp=stim:
  - 8 records with rec_stim=rec_resp=0..7 in order.
  - Each APPLY lasts 3 cycles.
  - done at cycle 33; pat_count=8.
- IN_W=2, rec_ready held low 5 cycles at the first EMIT:
  - rec_valid, rec_stim=0 and stim=0 stable throughout the stall.
  - Sweep resumes on release; 4 records total.
- IN_W=2, abort asserted during the EMIT of pattern 2 while rec_ready=1:
  - Next cycle busy=0 and stim=0, no done pulse.
  - pat_count=2 (the aborted record is not counted).
- Reset asserted mid-APPLY of pattern 1, then a fresh start:
  - All outputs at reset values after the edge.
  - The new sweep begins at stim=0 with pat_count=0.
- start pulsed repeatedly while busy: no restart, record sequence and done timing unchanged.

Source files
------------

// File: rtl/pattern_sweep_capture.sv
// Exhaustive input sweep engine: drives every IN_W-bit pattern in ascending order,
// samples the response after SETTLE cycles and streams (stim, resp) records. Optional MISR: SWEEP_MISR_EN.
module pattern_sweep_capture #(
  parameter int               IN_W   = 1,
  parameter int               OUT_W  = 1,
  parameter int               SETTLE = 1,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IN_W-1:0]  rec_stim,
  output logic [OUT_W-1:0] rec_resp,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    pat_count
`ifdef SWEEP_MISR_EN
  ,
  output logic [SIG_W-1:0] signature
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_EMIT, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [IN_W-1:0]  r_stim;
  logic [IN_W-1:0]  r_rec_stim;
  logic [OUT_W-1:0] r_rec_resp;
  logic             r_rec_valid;
  logic             r_done;
  logic [IN_W:0]    r_pat_count;
`ifdef SWEEP_MISR_EN
  logic [SIG_W-1:0] r_sig;
`endif

  always_ff @(posedge CK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stim      <= '0;
      r_rec_stim  <= '0;
      r_rec_resp  <= '0;
      r_rec_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pat_count <= '0;
`ifdef SWEEP_MISR_EN
      r_sig       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stim <= '0;
          // abort wins over a simultaneous start
          if (start && !abort) begin
            r_state     <= S_APPLY;
            r_cnt       <= CNT_LOAD;
            r_pat_count <= '0;
`ifdef SWEEP_MISR_EN
            r_sig       <= '0;
`endif
          end
        end
        S_APPLY: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_stim      <= '0;
            r_rec_valid <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rec_stim  <= r_stim;
            r_rec_resp  <= resp;
            r_rec_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          // abort drops the pending record without counting it
          if (abort) begin
            r_state     <= S_IDLE;
            r_stim      <= '0;
            r_rec_valid <= 1'b0;
          end else if (rec_ready) begin
            r_rec_valid <= 1'b0;
            r_pat_count <= r_pat_count + (IN_W+1)'(1);
`ifdef SWEEP_MISR_EN
            r_sig <= (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(r_rec_resp);
`endif
            if (&r_stim) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_stim  <= r_stim + IN_W'(1);
              r_cnt   <= CNT_LOAD;
              r_state <= S_APPLY;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_stim  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim      = r_stim;
  assign rec_valid = r_rec_valid;
  assign rec_stim  = r_rec_stim;
  assign rec_resp  = r_rec_resp;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pat_count = r_pat_count;
`ifdef SWEEP_MISR_EN
  assign signature = r_sig;
`endif

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Directed bench for pattern_sweep_capture: three configurations, scoreboarded records,
// timing, stall, abort, reset and repeated-start checks.
module tb_pattern_sweep_capture;
  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   b_apply = 0;

  // A: IN_W=1 OUT_W=1 SETTLE=1, resp = ~stim
  logic       a_start, a_abort, a_ready, a_valid, a_busy, a_done;
  logic [0:0] a_stim, a_resp, a_rstim, a_rresp;
  logic [1:0] a_cnt;
  // B: IN_W=3 OUT_W=3 SETTLE=3, resp = stim
  logic       b_start, b_abort, b_ready, b_valid, b_busy, b_done;
  logic [2:0] b_stim, b_resp, b_rstim, b_rresp;
  logic [3:0] b_cnt;
  // C: IN_W=2 OUT_W=2 SETTLE=2, resp = stim ^ 1
  logic       c_start, c_abort, c_ready, c_valid, c_busy, c_done;
  logic [1:0] c_stim, c_resp, c_rstim, c_rresp;
  logic [2:0] c_cnt;
`ifdef SWEEP_MISR_EN
  logic [15:0] a_sig, b_sig, c_sig;
`endif

  assign a_resp = ~a_stim;
  assign b_resp = b_stim;
  assign c_resp = c_stim ^ 2'b01;

  pattern_sweep_capture #(.IN_W(1), .OUT_W(1), .SETTLE(1)) u_a (
    .CK(CK), .reset(rst), .start(a_start), .abort(a_abort), .stim(a_stim), .resp(a_resp),
    .rec_valid(a_valid), .rec_ready(a_ready), .rec_stim(a_rstim), .rec_resp(a_rresp),
    .busy(a_busy), .done(a_done), .pat_count(a_cnt)
`ifdef SWEEP_MISR_EN
    , .signature(a_sig)
`endif
  );
  pattern_sweep_capture #(.IN_W(3), .OUT_W(3), .SETTLE(3)) u_b (
    .CK(CK), .reset(rst), .start(b_start), .abort(b_abort), .stim(b_stim), .resp(b_resp),
    .rec_valid(b_valid), .rec_ready(b_ready), .rec_stim(b_rstim), .rec_resp(b_rresp),
    .busy(b_busy), .done(b_done), .pat_count(b_cnt)
`ifdef SWEEP_MISR_EN
    , .signature(b_sig)
`endif
  );
  pattern_sweep_capture #(.IN_W(2), .OUT_W(2), .SETTLE(2)) u_c (
    .CK(CK), .reset(rst), .start(c_start), .abort(c_abort), .stim(c_stim), .resp(c_resp),
    .rec_valid(c_valid), .rec_ready(c_ready), .rec_stim(c_rstim), .rec_resp(c_rresp),
    .busy(c_busy), .done(c_done), .pat_count(c_cnt)
`ifdef SWEEP_MISR_EN
    , .signature(c_sig)
`endif
  );

  logic [1:0] qa[$];
  logic [5:0] qb[$];
  logic [3:0] qc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Record scoreboard: a record is consumed on an edge where valid & ready with no abort/reset.
  always @(negedge CK) begin
    if (!rst && a_valid && a_ready && !a_abort) begin
      if (qa.size() == 0) chk("a_unexpected_rec", 32'(qa.size()), 32'd1);
      else chk("a_rec", 32'({a_rstim, a_rresp}), 32'(qa.pop_front()));
    end
    if (!rst && b_valid && b_ready && !b_abort) begin
      if (qb.size() == 0) chk("b_unexpected_rec", 32'(qb.size()), 32'd1);
      else chk("b_rec", 32'({b_rstim, b_rresp}), 32'(qb.pop_front()));
    end
    if (!rst && c_valid && c_ready && !c_abort) begin
      if (qc.size() == 0) chk("c_unexpected_rec", 32'(qc.size()), 32'd1);
      else chk("c_rec", 32'({c_rstim, c_rresp}), 32'(qc.pop_front()));
    end
    if (b_busy && !b_valid && !b_done) b_apply++;
  end

  function automatic logic dn(input int w);
    case (w)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  // Pulse start (or keep toggling it for C) and count cycles until done, bounded.
  task automatic sweep(input int w, input bit tog, output int n);
    case (w)
      0:       a_start = 1'b1;
      1:       b_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    tick();
    n = 1;
    while (!dn(w) && n < 200) begin
      if (tog) c_start = ~c_start;
      else begin a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; end
      tick();
      n++;
    end
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
  endfunction

  initial begin
    int n;
    logic [15:0] sm;
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_ready = 1;
    b_start = 0; b_abort = 0; b_ready = 1;
    c_start = 0; c_abort = 0; c_ready = 1;
    repeat (2) tick();

    chk("rst_stim",   32'(a_stim),  32'd0);
    chk("rst_valid",  32'(a_valid), 32'd0);
    chk("rst_rstim",  32'(b_rstim), 32'd0);
    chk("rst_rresp",  32'(b_rresp), 32'd0);
    chk("rst_busy",   32'(c_busy),  32'd0);
    chk("rst_done",   32'(c_done),  32'd0);
    chk("rst_cnt",    32'(b_cnt),   32'd0);
    rst = 1'b0;
    tick();

    // A: two-pattern sweep
    qa.push_back(2'b01);
    qa.push_back(2'b10);
    sweep(0, 1'b0, n);
    chk("a_done_cycle", 32'(n), 32'd5);
    chk("a_pat_count", 32'(a_cnt), 32'd2);
`ifdef SWEEP_MISR_EN
    chk("a_signature", 32'(a_sig), 32'h0002);
`endif
    tick();
    chk("a_done_one_cycle", 32'(a_done), 32'd0);
    chk("a_idle_busy", 32'(a_busy), 32'd0);
    chk("a_idle_stim", 32'(a_stim), 32'd0);
    chk("a_q_empty", 32'(qa.size()), 32'd0);

    // B: 8 patterns, SETTLE=3
    b_apply = 0;
    sm = '0;
    for (int i = 0; i < 8; i++) begin
      qb.push_back({3'(i), 3'(i)});
      sm = misr(sm, 16'(i));
    end
    sweep(1, 1'b0, n);
    chk("b_done_cycle", 32'(n), 32'd33);
    chk("b_pat_count", 32'(b_cnt), 32'd8);
    chk("b_apply_cycles", 32'(b_apply), 32'd24);
    chk("b_q_empty", 32'(qb.size()), 32'd0);
`ifdef SWEEP_MISR_EN
    chk("b_signature", 32'(b_sig), 32'(sm));
`endif
    tick();

    // C: stall the first record for 5 cycles
    for (int i = 0; i < 4; i++) qc.push_back({2'(i), 2'(i) ^ 2'b01});
    c_ready = 1'b0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    n = 0;
    while (!c_valid && n < 20) begin tick(); n++; end
    chk("c_stall_reached", 32'(c_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("c_stall_valid", 32'(c_valid), 32'd1);
      chk("c_stall_rstim", 32'(c_rstim), 32'd0);
      chk("c_stall_stim",  32'(c_stim),  32'd0);
      tick();
    end
    c_ready = 1'b1;
    n = 0;
    while (!c_done && n < 100) begin tick(); n++; end
    chk("c_stall_done", 32'(c_done), 32'd1);
    chk("c_stall_count", 32'(c_cnt), 32'd4);
    chk("c_stall_q_empty", 32'(qc.size()), 32'd0);
    tick();

    // C: abort during EMIT of pattern 2
    qc.push_back(4'h1);
    qc.push_back(4'h4);
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    n = 0;
    while (!(c_valid && c_rstim == 2'd2) && n < 50) begin tick(); n++; end
    chk("c_abort_reached", 32'(c_rstim), 32'd2);
    c_abort = 1'b1;
    tick();
    c_abort = 1'b0;
    chk("c_abort_busy",  32'(c_busy),  32'd0);
    chk("c_abort_stim",  32'(c_stim),  32'd0);
    chk("c_abort_done",  32'(c_done),  32'd0);
    chk("c_abort_valid", 32'(c_valid), 32'd0);
    chk("c_abort_count", 32'(c_cnt),   32'd2);
    chk("c_abort_q_empty", 32'(qc.size()), 32'd0);
    tick();
    chk("c_abort_no_done", 32'(c_done), 32'd0);

    // C: reset mid-APPLY of pattern 1, then a fresh sweep
    for (int i = 0; i < 4; i++) qc.push_back({2'(i), 2'(i) ^ 2'b01});
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    n = 0;
    while (!(c_stim == 2'd1 && !c_valid) && n < 50) begin tick(); n++; end
    chk("c_rst_reached", 32'(c_stim), 32'd1);
    rst = 1'b1;
    tick();
    chk("c_rst_stim",  32'(c_stim),  32'd0);
    chk("c_rst_valid", 32'(c_valid), 32'd0);
    chk("c_rst_rstim", 32'(c_rstim), 32'd0);
    chk("c_rst_rresp", 32'(c_rresp), 32'd0);
    chk("c_rst_busy",  32'(c_busy),  32'd0);
    chk("c_rst_count", 32'(c_cnt),   32'd0);
`ifdef SWEEP_MISR_EN
    chk("c_rst_sig",   32'(c_sig),   32'd0);
`endif
    rst = 1'b0;
    qc.delete();
    for (int i = 0; i < 4; i++) qc.push_back({2'(i), 2'(i) ^ 2'b01});
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("c_fresh_stim",  32'(c_stim), 32'd0);
    chk("c_fresh_count", 32'(c_cnt),  32'd0);
    chk("c_fresh_busy",  32'(c_busy), 32'd1);
    n = 0;
    while (!c_done && n < 100) begin tick(); n++; end
    chk("c_fresh_pat_count", 32'(c_cnt), 32'd4);
    chk("c_fresh_q_empty", 32'(qc.size()), 32'd0);
    tick();

    // C: start toggled throughout the sweep
    for (int i = 0; i < 4; i++) qc.push_back({2'(i), 2'(i) ^ 2'b01});
    sweep(2, 1'b1, n);
    chk("c_restart_done_cycle", 32'(n), 32'd13);
    chk("c_restart_count", 32'(c_cnt), 32'd4);
    chk("c_restart_q_empty", 32'(qc.size()), 32'd0);
    tick();
    chk("c_restart_idle", 32'(c_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
